pc_control: RTL and testbench

//  Next-PC and condition-flag unit of the single-cycle datapath; consumer of the decoder's

---
 rtl/pc_control.sv | 127 ++++++++++++
 tb/tb_pc_control.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_control.sv
// Next-PC and condition-flag unit: holds PC, stored {N,Z,V} flags and run/halt state,
// evaluates branch conditions against stored flags and selects the next instruction address.
module pc_control #(
    parameter int               WIDTH    = 16,
    parameter int               IMM_W    = 9,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branch_en,
    input  logic             branch,
    input  logic             hlt,
    input  logic             stall,
    input  logic [2:0]       cond,
    input  logic [IMM_W-1:0] imm,
    input  logic [WIDTH-1:0] reg_tgt,
    input  logic [2:0]       flag_we,
    input  logic [2:0]       flag_in,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus2,
    output logic [2:0]       flags,
    output logic             taken,
    output logic             halted
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-2){1'b0}}, 2'b10};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [2:0]       flags_q, flags_d;
    logic             halted_q, halted_d;

    logic [WIDTH-1:0] imm_ext_s;
    logic [WIDTH-1:0] br_off_s;
    logic [WIDTH-1:0] pc_plus2_s;
    logic             cond_ok_s;
    logic             taken_s;

    // Condition codes are evaluated on the stored flags f = {N,Z,V}.
    function automatic logic cond_eval(input logic [2:0] c, input logic [2:0] f);
        logic n, z, v, r;
        n = f[2];
        z = f[1];
        v = f[0];
        case (c)
            3'b000:  r = ~z;
            3'b001:  r = z;
            3'b010:  r = ~z & ~n;
            3'b011:  r = n;
            3'b100:  r = z | (~z & ~n);
            3'b101:  r = n | z;
            3'b110:  r = v;
            3'b111:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Address arithmetic and branch decision for the current instruction.
    always_comb begin
        imm_ext_s  = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
        br_off_s   = {imm_ext_s[WIDTH-2:0], 1'b0};
        pc_plus2_s = pc_q + PC_STEP;
        cond_ok_s  = cond_eval(cond, flags_q);
        taken_s    = branch_en & cond_ok_s & (state_q == RUN) & ~stall;
    end

    // Next-state logic; hlt takes priority over a same-cycle branch.
    always_comb begin
        pc_d     = pc_q;
        flags_d  = flags_q;
        state_d  = state_q;
        halted_d = halted_q;
        case (state_q)
            RUN: begin
                if (!stall) begin
                    if (hlt) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else if (taken_s) begin
                        pc_d = branch ? reg_tgt : (pc_plus2_s + br_off_s);
                    end else begin
                        pc_d = pc_plus2_s;
                    end
                    flags_d = (flag_we & flag_in) | (~flag_we & flags_q);
                end else begin
                    pc_d = pc_q;
                end
            end
            HALT: begin
                state_d  = HALT;
                halted_d = 1'b1;
            end
            default: begin
                state_d  = HALT;
                halted_d = 1'b1;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            flags_q  <= 3'b000;
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            flags_q  <= flags_d;
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    assign pc       = pc_q;
    assign pc_plus2 = pc_plus2_s;
    assign flags    = flags_q;
    assign taken    = taken_s;
    assign halted   = halted_q;

endmodule

// File: tb/tb_pc_control.sv
// Self-checking bench for pc_control: directed corner sequences, a condition table sweep,
// and random stimulus compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_pc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_en, branch, hlt, stall;
    logic [2:0]  cond;
    logic [8:0]  imm;
    logic [15:0] reg_tgt;
    logic [2:0]  flag_we, flag_in;
    logic [15:0] pc, pc_plus2;
    logic [2:0]  flags;
    logic        taken, halted;

    int checks = 0;
    int errors = 0;

    int        pc_m;
    logic [2:0] flags_m;
    bit        halted_m;

    typedef struct {
        logic [2:0] cond;
        logic [7:0] mask;   // bit f set when condition holds for stored flags f = {N,Z,V}
    } cond_vec_t;
    cond_vec_t vecs[8];

    pc_control #(.WIDTH(16), .IMM_W(9), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .branch_en(branch_en), .branch(branch), .hlt(hlt),
        .stall(stall), .cond(cond), .imm(imm), .reg_tgt(reg_tgt), .flag_we(flag_we),
        .flag_in(flag_in), .pc(pc), .pc_plus2(pc_plus2), .flags(flags), .taken(taken),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit model_cond(input int c, input logic [2:0] f);
        bit n, z, v;
        n = f[2]; z = f[1]; v = f[0];
        case (c)
            0: return !z;
            1: return z;
            2: return !z && !n;
            3: return n;
            4: return z || !n;
            5: return n || z;
            6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit model_taken();
        return branch_en && !halted_m && !stall && model_cond(int'(cond), flags_m);
    endfunction

    task automatic model_update();
        int off;
        if (!halted_m && !stall) begin
            if (hlt) begin
                halted_m = 1'b1;
            end else if (model_taken()) begin
                if (branch) begin
                    pc_m = int'(reg_tgt);
                end else begin
                    off  = (imm >= 9'd256) ? int'(imm) - 512 : int'(imm);
                    pc_m = (pc_m + 2 + 2 * off) & 32'hFFFF;
                end
            end else begin
                pc_m = (pc_m + 2) & 32'hFFFF;
            end
            flags_m = (flags_m & ~flag_we) | (flag_in & flag_we);
        end
    endtask

    task automatic idle_inputs();
        branch_en = 1'b0; branch = 1'b0; hlt = 1'b0; stall = 1'b0;
        cond = 3'd0; imm = 9'd0; reg_tgt = 16'h0000; flag_we = 3'b000; flag_in = 3'b000;
    endtask

    // Called at posedge+1; checks combinational outputs mid-cycle, registered ones after the edge.
    task automatic tick();
        @(negedge clk);
        chk("taken", {31'd0, taken}, {31'd0, model_taken()});
        chk("pc_plus2", {16'd0, pc_plus2}, (pc_m + 2) & 32'hFFFF);
        model_update();
        @(posedge clk);
        #1;
        chk("pc", {16'd0, pc}, pc_m);
        chk("flags", {29'd0, flags}, {29'd0, flags_m});
        chk("halted", {31'd0, halted}, {31'd0, halted_m});
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        pc_m = 0; flags_m = 3'b000; halted_m = 1'b0;
        chk("rst_pc", {16'd0, pc}, 32'h0);
        chk("rst_flags", {29'd0, flags}, 32'h0);
        chk("rst_halted", {31'd0, halted}, 32'h0);
        rst = 1'b0;
    endtask

    task automatic br_to(input logic [15:0] tgt);
        idle_inputs();
        branch_en = 1'b1; branch = 1'b1; cond = 3'b111; reg_tgt = tgt;
        tick();
        idle_inputs();
    endtask

    task automatic set_flags(input logic [2:0] f);
        idle_inputs();
        flag_we = 3'b111; flag_in = f;
        tick();
        idle_inputs();
    endtask

    initial begin
        int p;
        bit exp_t;
        logic [2:0] snap_flags;

        vecs[0] = '{3'b000, 8'h33};
        vecs[1] = '{3'b001, 8'hCC};
        vecs[2] = '{3'b010, 8'h03};
        vecs[3] = '{3'b011, 8'hF0};
        vecs[4] = '{3'b100, 8'hCF};
        vecs[5] = '{3'b101, 8'hFC};
        vecs[6] = '{3'b110, 8'hAA};
        vecs[7] = '{3'b111, 8'hFF};

        idle_inputs();
        rst = 1'b1;
        pc_m = 0; flags_m = 3'b000; halted_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_pc", {16'd0, pc}, 32'h0);
        chk("init_flags", {29'd0, flags}, 32'h0);
        chk("init_halted", {31'd0, halted}, 32'h0);
        rst = 1'b0;

        // Asynchronous reset mid-run with non-zero PC and flags
        br_to(16'h0040);
        set_flags(3'b111);
        chk("t1_pre_flags", {29'd0, flags}, 32'h7);
        do_reset();

        // PC-relative branches, negative and positive offsets
        br_to(16'h0010);
        branch_en = 1'b1; cond = 3'b111; imm = 9'h1FE;
        tick();
        chk("t2_back", {16'd0, pc}, 32'h000E);
        br_to(16'h0010);
        branch_en = 1'b1; cond = 3'b111; imm = 9'h004;
        tick();
        chk("t2_fwd", {16'd0, pc}, 32'h001A);
        idle_inputs();

        // Condition table sweep: every code against every stored flag pattern
        for (int v = 0; v < 8; v++) begin
            for (int f = 0; f < 8; f++) begin
                set_flags(3'(f));
                branch_en = 1'b1; cond = vecs[v].cond; imm = 9'h010;
                p = pc_m;
                exp_t = vecs[v].mask[f];
                #1;
                chk("t3_taken", {31'd0, taken}, {31'd0, exp_t});
                tick();
                chk("t3_pc", {16'd0, pc}, exp_t ? ((p + 2 + 32) & 32'hFFFF) : ((p + 2) & 32'hFFFF));
                idle_inputs();
            end
        end

        // Same-cycle flag write and EQ branch: branch sees old Z
        set_flags(3'b000);
        branch_en = 1'b1; cond = 3'b001; imm = 9'h004; flag_we = 3'b010; flag_in = 3'b010;
        p = pc_m;
        tick();
        chk("t4_not_taken", {16'd0, pc}, (p + 2) & 32'hFFFF);
        chk("t4_flags", {29'd0, flags}, 32'h2);
        idle_inputs();
        branch_en = 1'b1; cond = 3'b001; imm = 9'h004;
        p = pc_m;
        tick();
        chk("t4_taken", {16'd0, pc}, (p + 10) & 32'hFFFF);
        idle_inputs();

        // Register target and address wrap
        br_to(16'h1234);
        chk("t5_br", {16'd0, pc}, 32'h1234);
        br_to(16'hFFFE);
        tick();
        chk("t5_wrap", {16'd0, pc}, 32'h0000);

        // Halt freezes everything until reset
        br_to(16'h0020);
        hlt = 1'b1; branch_en = 1'b1; cond = 3'b111; imm = 9'h008;
        tick();
        chk("t6_pc", {16'd0, pc}, 32'h0020);
        chk("t6_halted", {31'd0, halted}, 32'h1);
        snap_flags = flags_m;
        for (int i = 0; i < 10; i++) begin
            branch_en = 1'b1; branch = 1'($urandom); cond = 3'($urandom); imm = 9'($urandom);
            reg_tgt = 16'($urandom); flag_we = 3'b111; flag_in = ~snap_flags;
            hlt = 1'($urandom); stall = 1'b0;
            tick();
            chk("t6_frozen_pc", {16'd0, pc}, 32'h0020);
        end
        chk("t6_frozen_flags", {29'd0, flags}, {29'd0, snap_flags});
        idle_inputs();
        do_reset();
        tick();
        chk("t6_resume", {16'd0, pc}, 32'h0002);

        // Random stimulus against the reference model
        for (int i = 0; i < 400; i++) begin
            branch_en = 1'($urandom);
            branch    = 1'($urandom);
            hlt       = ($urandom_range(0, 49) == 0);
            stall     = ($urandom_range(0, 4) == 0);
            cond      = 3'($urandom);
            imm       = 9'($urandom);
            reg_tgt   = 16'($urandom);
            flag_we   = 3'($urandom);
            flag_in   = 3'($urandom);
            tick();
            if (halted_m && ($urandom_range(0, 3) == 0)) begin
                idle_inputs();
                do_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
